button_event_arbiter: RTL and testbench

BUTTON_EVENT_ARBITER -- requirements
Module: button_event_arbiter

---
 rtl/button_event_arbiter.sv | 231 +++++++++++++++++++++++
 tb/tb_button_event_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : button_event_arbiter
// Summary  : Converts debounced button levels into press / release (and
//            optionally hold) events, arbitrates pending events round-robin
//            across buttons and queues them in a small event FIFO with a
//            valid/ready consumer interface and a sticky overflow flag.
// Options  : define BUTTON_HOLD_EN to add per-button hold counters and
//            type-10 hold events; without it i_hold_threshold is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module button_event_arbiter #(
   parameter int BUTTON_COUNT       = 5,
   parameter int FIFO_DEPTH         = 4,
   parameter int HOLD_COUNTER_WIDTH = 24
) (
   input  logic                            i_clock,
   input  logic                            i_reset,
   input  logic [BUTTON_COUNT-1:0]         i_buttons,
   input  logic [HOLD_COUNTER_WIDTH-1:0]   i_hold_threshold,
   output logic                            o_event_valid,
   input  logic                            i_event_ready,
   output logic [$clog2(BUTTON_COUNT)-1:0] o_event_id,
   output logic [1:0]                      o_event_type,
   output logic                            o_overflow,
   input  logic                            i_clear_overflow
);

   localparam int c_id_w  = $clog2(BUTTON_COUNT);
   localparam int c_ptr_w = $clog2(FIFO_DEPTH);

   localparam logic [1:0] c_type_press   = 2'b00;
   localparam logic [1:0] c_type_release = 2'b01;
   localparam logic [1:0] c_type_hold    = 2'b10;

   localparam logic [c_id_w:0]   c_count_ext = (c_id_w+1)'(BUTTON_COUNT);
   localparam logic [c_id_w-1:0] c_last_id   = c_id_w'(BUTTON_COUNT-1);
   localparam logic [c_id_w-1:0] c_id_one    = c_id_w'(1);
   localparam logic [c_ptr_w:0]  c_ptr_one   = (c_ptr_w+1)'(1);

   // Button sampling and captured edges
   logic [BUTTON_COUNT-1:0] btn_q;
   logic [BUTTON_COUNT-1:0] rise_q;
   logic [BUTTON_COUNT-1:0] fall_q;

   // Pending event flags, one set per button
   logic [BUTTON_COUNT-1:0] press_q, press_d;
   logic [BUTTON_COUNT-1:0] hold_q,  hold_d;
   logic [BUTTON_COUNT-1:0] rel_q,   rel_d;
   logic [BUTTON_COUNT-1:0] w_pend_any;
   logic [BUTTON_COUNT-1:0] w_hold_fire;

   // Arbiter
   logic [c_id_w-1:0]       rr_q, rr_d;
   logic                    w_grant;
   logic [c_id_w-1:0]       w_grant_idx;
   logic [1:0]              w_grant_type;
   logic [c_id_w:0]         w_scan;
   logic [BUTTON_COUNT-1:0] w_clr_press;
   logic [BUTTON_COUNT-1:0] w_clr_hold;
   logic [BUTTON_COUNT-1:0] w_clr_rel;

   // Event FIFO; the extra pointer MSB separates full from empty
   logic [c_ptr_w:0]   wr_ptr_q, wr_ptr_d;
   logic [c_ptr_w:0]   rd_ptr_q, rd_ptr_d;
   logic [c_id_w-1:0]  id_mem_q   [FIFO_DEPTH];
   logic [1:0]         type_mem_q [FIFO_DEPTH];
   logic               w_empty;
   logic               w_full;
   logic               w_pop;
   logic               w_wr_ok;

   // Sticky overflow
   logic ovf_q, ovf_d;
   logic w_new_ovf;

   // Sample levels and register this cycle's edges; the pending stage
   // consumes them one cycle later, giving a fixed 3-cycle input-to-valid path
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         btn_q  <= '0;
         rise_q <= '0;
         fall_q <= '0;
      end else begin
         btn_q  <= i_buttons;
         rise_q <= i_buttons & ~btn_q;
         fall_q <= ~i_buttons & btn_q;
      end
   end

`ifdef BUTTON_HOLD_EN
   // One hold counter per button; fires once per press when it hits the threshold
   for (genvar gi = 0; gi < BUTTON_COUNT; gi++) begin : g_hold
      logic [HOLD_COUNTER_WIDTH-1:0] cnt_q;
      logic                          done_q;

      assign w_hold_fire[gi] = btn_q[gi] & ~done_q &
                               (i_hold_threshold != '0) &
                               (cnt_q == i_hold_threshold);

      // Count cycles the sampled button stays pressed; saturate instead of wrapping
      always_ff @(posedge i_clock) begin
         if (i_reset || !btn_q[gi]) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
         end else begin
            if (cnt_q != '1) begin
               cnt_q <= cnt_q + HOLD_COUNTER_WIDTH'(1);
            end
            if (w_hold_fire[gi]) begin
               done_q <= 1'b1;
            end
         end
      end
   end
`else
   logic w_unused_threshold;

   assign w_hold_fire        = '0;
   assign w_unused_threshold = ^i_hold_threshold;
`endif

   // FIFO status: a slot is available when not full, or when the head leaves this cycle
   assign w_empty = (wr_ptr_q == rd_ptr_q);
   assign w_full  = (wr_ptr_q[c_ptr_w] != rd_ptr_q[c_ptr_w]) &&
                    (wr_ptr_q[c_ptr_w-1:0] == rd_ptr_q[c_ptr_w-1:0]);
   assign w_pop   = ~w_empty & i_event_ready;
   assign w_wr_ok = ~w_full | w_pop;

   assign w_pend_any = press_q | hold_q | rel_q;

   // Round-robin search starting at rr_q for the first button with anything pending
   always_comb begin
      w_grant     = 1'b0;
      w_grant_idx = '0;
      w_scan      = '0;
      for (int k = 0; k < BUTTON_COUNT; k++) begin
         w_scan = {1'b0, rr_q} + (c_id_w+1)'(k);
         if (w_scan >= c_count_ext) begin
            w_scan = w_scan - c_count_ext;
         end
         if (w_wr_ok && !w_grant && w_pend_any[w_scan[c_id_w-1:0]]) begin
            w_grant     = 1'b1;
            w_grant_idx = w_scan[c_id_w-1:0];
         end
      end
   end

   // Pick the flag of the granted button: press, then hold, then release
   always_comb begin
      w_grant_type = c_type_press;
      w_clr_press  = '0;
      w_clr_hold   = '0;
      w_clr_rel    = '0;
      if (w_grant) begin
         if (press_q[w_grant_idx]) begin
            w_grant_type             = c_type_press;
            w_clr_press[w_grant_idx] = 1'b1;
         end else if (hold_q[w_grant_idx]) begin
            w_grant_type            = c_type_hold;
            w_clr_hold[w_grant_idx] = 1'b1;
         end else begin
            w_grant_type           = c_type_release;
            w_clr_rel[w_grant_idx] = 1'b1;
         end
      end
   end

   // Next pending flags, overflow on an edge hitting a still-pending flag, pointer advance
   always_comb begin
      press_d   = (press_q & ~w_clr_press) | rise_q;
      hold_d    = (hold_q  & ~w_clr_hold)  | w_hold_fire;
      rel_d     = (rel_q   & ~w_clr_rel)   | fall_q;
      w_new_ovf = (|(rise_q      & press_q & ~w_clr_press)) |
                  (|(w_hold_fire & hold_q  & ~w_clr_hold))  |
                  (|(fall_q      & rel_q   & ~w_clr_rel));
      ovf_d     = (ovf_q & ~i_clear_overflow) | w_new_ovf;
      rr_d      = rr_q;
      if (w_grant) begin
         rr_d = (w_grant_idx == c_last_id) ? '0 : (w_grant_idx + c_id_one);
      end
   end

   // FIFO pointer next state
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (w_grant) begin
         wr_ptr_d = wr_ptr_q + c_ptr_one;
      end
      if (w_pop) begin
         rd_ptr_d = rd_ptr_q + c_ptr_one;
      end
   end

   // Control state: pending flags, arbiter pointer, FIFO pointers, overflow
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         press_q  <= '0;
         hold_q   <= '0;
         rel_q    <= '0;
         rr_q     <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         press_q  <= press_d;
         hold_q   <= hold_d;
         rel_q    <= rel_d;
         rr_q     <= rr_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         ovf_q    <= ovf_d;
      end
   end

   // FIFO storage; contents need no reset since the pointers define validity
   always_ff @(posedge i_clock) begin
      if (w_grant) begin
         id_mem_q[wr_ptr_q[c_ptr_w-1:0]]   <= w_grant_idx;
         type_mem_q[wr_ptr_q[c_ptr_w-1:0]] <= w_grant_type;
      end
   end

   assign o_event_valid = ~w_empty;
   assign o_event_id    = id_mem_q[rd_ptr_q[c_ptr_w-1:0]];
   assign o_event_type  = type_mem_q[rd_ptr_q[c_ptr_w-1:0]];
   assign o_overflow    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_button_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_event_arbiter
// Summary  : Self-checking bench for button_event_arbiter: a directed vector
//            table, hand-written multi-cycle sequences, and a randomized run
//            compared against an event-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_event_arbiter;

   localparam int N    = 5;
   localparam int FD   = 4;
   localparam int HCW  = 24;
   localparam int ID_W = $clog2(N);

   logic            clk;
   logic            rst;
   logic [N-1:0]    btn;
   logic [HCW-1:0]  thr;
   logic            rdy;
   logic            clr;
   logic            valid;
   logic [ID_W-1:0] ev_id;
   logic [1:0]      ev_type;
   logic            ovf;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      int id;
      int typ;
   } ev_t;

   typedef struct {
      logic [N-1:0] btn;
      bit           rdy;
      bit           exp_v;
      int           exp_id;
      int           exp_t;
      bit           exp_ovf;
   } vec_t;

   ev_t cap[$];
   ev_t exp_q[$];

   // Reference model state
   logic [N-1:0] m_prev, m_rise, m_fall, m_pp, m_ph, m_pr;
   int           m_p;
   ev_t          m_q[$];
   bit           m_ovf;
   int unsigned  m_cnt[N];
   bit           m_hd[N];

   button_event_arbiter #(
      .BUTTON_COUNT      (N),
      .FIFO_DEPTH        (FD),
      .HOLD_COUNTER_WIDTH(HCW)
   ) dut (
      .i_clock         (clk),
      .i_reset         (rst),
      .i_buttons       (btn),
      .i_hold_threshold(thr),
      .o_event_valid   (valid),
      .i_event_ready   (rdy),
      .o_event_id      (ev_id),
      .o_event_type    (ev_type),
      .o_overflow      (ovf),
      .i_clear_overflow(clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic ev_t mk(input int id, input int typ);
      ev_t e;
      e.id  = id;
      e.typ = typ;
      return e;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // One clock of the behavioural model using the inputs about to be sampled
   task automatic model_step();
      bit           pop;
      bit           wr_ok;
      bit           found;
      bit           new_ovf;
      int           g;
      int           gt;
      int           b;
      logic [N-1:0] fire;
      if (rst) begin
         m_prev = '0; m_rise = '0; m_fall = '0;
         m_pp = '0; m_ph = '0; m_pr = '0;
         m_p = 0; m_q.delete(); m_ovf = 1'b0;
         for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0;
            m_hd[i]  = 1'b0;
         end
         return;
      end
      fire = '0;
`ifdef BUTTON_HOLD_EN
      for (int i = 0; i < N; i++) begin
         fire[i] = m_prev[i] && (thr != 0) && !m_hd[i] && (m_cnt[i] == thr);
      end
`endif
      pop   = (m_q.size() != 0) && rdy;
      wr_ok = (m_q.size() < FD) || pop;
      found = 1'b0;
      g = 0;
      gt = 0;
      if (wr_ok) begin
         for (int k = 0; k < N; k++) begin
            b = (m_p + k) % N;
            if (!found && (m_pp[b] || m_ph[b] || m_pr[b])) begin
               found = 1'b1;
               g     = b;
               gt    = m_pp[b] ? 0 : (m_ph[b] ? 2 : 1);
            end
         end
      end
      if (pop) void'(m_q.pop_front());
      if (found) begin
         m_q.push_back(mk(g, gt));
         if (gt == 0) m_pp[g] = 1'b0;
         else if (gt == 2) m_ph[g] = 1'b0;
         else m_pr[g] = 1'b0;
         m_p = (g + 1) % N;
      end
      new_ovf = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (m_rise[i]) begin if (m_pp[i]) new_ovf = 1'b1; m_pp[i] = 1'b1; end
         if (m_fall[i]) begin if (m_pr[i]) new_ovf = 1'b1; m_pr[i] = 1'b1; end
         if (fire[i])   begin if (m_ph[i]) new_ovf = 1'b1; m_ph[i] = 1'b1; end
      end
      m_ovf = (m_ovf && !clr) || new_ovf;
`ifdef BUTTON_HOLD_EN
      for (int i = 0; i < N; i++) begin
         if (!m_prev[i]) begin
            m_cnt[i] = 0;
            m_hd[i]  = 1'b0;
         end else begin
            if (m_cnt[i] != (32'd1 << HCW) - 1) m_cnt[i] = m_cnt[i] + 1;
            if (fire[i]) m_hd[i] = 1'b1;
         end
      end
`endif
      m_rise = btn & ~m_prev;
      m_fall = ~btn & m_prev;
      m_prev = btn;
   endtask

   // Advance one clock; inputs were set at the preceding negedge
   task automatic step();
      model_step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Run n cycles, recording every event the consumer actually takes
   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         if (valid && rdy) cap.push_back(mk(int'(ev_id), int'(ev_type)));
         step();
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; btn = '0; rdy = 1'b0; clr = 1'b0;
      step();
      step();
      rst = 1'b0;
      cap.delete();
   endtask

   task automatic check_events(input string nm);
      chk($sformatf("%s count", nm), cap.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < cap.size()) begin
            chk($sformatf("%s[%0d] id", nm, i), cap[i].id, exp_q[i].id);
            chk($sformatf("%s[%0d] type", nm, i), cap[i].typ, exp_q[i].typ);
         end
      end
      cap.delete();
      exp_q.delete();
   endtask

   task automatic check_model(input int cyc);
      chk($sformatf("rand valid @%0d", cyc), int'(valid), int'(m_q.size() != 0));
      chk($sformatf("rand ovf @%0d", cyc), int'(ovf), int'(m_ovf));
      if (m_q.size() != 0) begin
         chk($sformatf("rand id @%0d", cyc), int'(ev_id), m_q[0].id);
         chk($sformatf("rand type @%0d", cyc), int'(ev_type), m_q[0].typ);
      end
   endtask

   initial begin
      vec_t vt[8];
      int   stall_pct;
      int   bi;

      // Single press/release of button 2 with an always-ready consumer
      vt[0] = '{5'b00100, 1'b1, 1'b0, 0, 0, 1'b0};
      vt[1] = '{5'b00100, 1'b1, 1'b0, 0, 0, 1'b0};
      vt[2] = '{5'b00100, 1'b1, 1'b1, 2, 0, 1'b0};
      vt[3] = '{5'b00100, 1'b1, 1'b0, 0, 0, 1'b0};
      vt[4] = '{5'b00000, 1'b1, 1'b0, 0, 0, 1'b0};
      vt[5] = '{5'b00000, 1'b1, 1'b0, 0, 0, 1'b0};
      vt[6] = '{5'b00000, 1'b1, 1'b1, 2, 1, 1'b0};
      vt[7] = '{5'b00000, 1'b1, 1'b0, 0, 0, 1'b0};

      rst = 1'b1; btn = '0; thr = HCW'(10); rdy = 1'b0; clr = 1'b0;
      @(negedge clk);
      do_reset();
      chk("reset valid", int'(valid), 0);
      chk("reset ovf", int'(ovf), 0);

      for (int i = 0; i < 8; i++) begin
         btn = vt[i].btn;
         rdy = vt[i].rdy;
         step();
         chk($sformatf("vec%0d valid", i), int'(valid), int'(vt[i].exp_v));
         chk($sformatf("vec%0d ovf", i), int'(ovf), int'(vt[i].exp_ovf));
         if (vt[i].exp_v) begin
            chk($sformatf("vec%0d id", i), int'(ev_id), vt[i].exp_id);
            chk($sformatf("vec%0d type", i), int'(ev_type), vt[i].exp_t);
         end
      end

      // Simultaneous presses of 0,1,4 from pointer 0; release order proves pointer back at 0
      do_reset();
      rdy = 1'b1;
      btn = 5'b10011;
      run(10);
      exp_q.push_back(mk(0, 0)); exp_q.push_back(mk(1, 0)); exp_q.push_back(mk(4, 0));
      check_events("rr press");
      btn = 5'b00000;
      run(10);
      exp_q.push_back(mk(0, 1)); exp_q.push_back(mk(1, 1)); exp_q.push_back(mk(4, 1));
      check_events("rr release");

      // Six events against a stalled consumer: four queued, two wait, none lost
      do_reset();
      rdy = 1'b0;
      btn = 5'b11111;
      run(8);
      btn = 5'b11110;
      run(6);
      chk("stall valid", int'(valid), 1);
      chk("stall ovf", int'(ovf), 0);
      chk("stall head id", int'(ev_id), 0);
      rdy = 1'b1;
      run(15);
      exp_q.push_back(mk(0, 0)); exp_q.push_back(mk(1, 0)); exp_q.push_back(mk(2, 0));
      exp_q.push_back(mk(3, 0)); exp_q.push_back(mk(4, 0)); exp_q.push_back(mk(0, 1));
      check_events("stall drain");
      chk("stall drain ovf", int'(ovf), 0);

      // Second press of button 3 while its press flag waits on a full FIFO
      do_reset();
      rdy = 1'b0;
      btn = 5'b10111;
      run(8);
      btn = 5'b11111;
      run(4);
      btn = 5'b10111;
      run(4);
      chk("dup ovf before", int'(ovf), 0);
      btn = 5'b11111;
      run(4);
      chk("dup ovf set", int'(ovf), 1);
      rdy = 1'b1;
      run(15);
      exp_q.push_back(mk(0, 0)); exp_q.push_back(mk(1, 0)); exp_q.push_back(mk(2, 0));
      exp_q.push_back(mk(4, 0)); exp_q.push_back(mk(3, 0)); exp_q.push_back(mk(3, 1));
      check_events("dup drain");
      chk("dup ovf sticky", int'(ovf), 1);
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk("dup ovf cleared", int'(ovf), 0);

      // Long press of button 1 with threshold 10
      do_reset();
      thr = HCW'(10);
      rdy = 1'b1;
      btn = 5'b00010;
      run(30);
      btn = 5'b00000;
      run(10);
      exp_q.push_back(mk(1, 0));
`ifdef BUTTON_HOLD_EN
      exp_q.push_back(mk(1, 2));
`endif
      exp_q.push_back(mk(1, 1));
      check_events("hold seq");

      // Reset mid-operation with three queued events, button 0 held through it
      do_reset();
      rdy = 1'b0;
      btn = 5'b00111;
      run(7);
      chk("mid-rst queued valid", int'(valid), 1);
      rst = 1'b1;
      btn = 5'b00001;
      step();
      step();
      chk("mid-rst valid", int'(valid), 0);
      chk("mid-rst ovf", int'(ovf), 0);
      rst = 1'b0;
      rdy = 1'b1;
      cap.delete();
      run(12);
      exp_q.push_back(mk(0, 0));
      check_events("after rst");

      // Randomized traffic against the reference model
      do_reset();
      stall_pct = 0;
      for (int c = 0; c < 4000; c++) begin
         if (c % 400 == 0) begin
            stall_pct = int'($urandom_range(0, 90));
            thr       = HCW'($urandom_range(0, 12));
         end
         if ($urandom_range(0, 5) == 0) begin
            bi  = int'($urandom_range(0, N - 1));
            btn = btn ^ (N'(1) << bi);
         end
         rdy = (int'($urandom_range(0, 99)) >= stall_pct);
         clr = ($urandom_range(0, 31) == 0);
         rst = ($urandom_range(0, 599) == 0);
         step();
         check_model(c);
      end
      rst = 1'b0;
      clr = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
